// File: rtl/decoder.sv
// rtl/decoder.sv - latched MIPS instruction register with combinational control decode
// Optional MDU instruction decode enabled by defining MDU_DECODE_EN.
module decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        en,
    input  logic        flush,
    output logic [3:0]  MDUwrite,
    output logic [3:0]  MDUcal,
    output logic        start,
    output logic [1:0]  MDUread,
    output logic        RegWrite,
    output logic [1:0]  RegDst,
    output logic [3:0]  ALUop,
    output logic        ALUsrc,
    output logic        ExtOp,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic [2:0]  NPCsel,
    output logic        illegal
);
    logic [31:0] instr_q;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        known;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= 32'h0;
        end else if (flush) begin
            instr_q <= 32'h0;
        end else if (en) begin
            instr_q <= Instr;
        end
    end

    assign op    = instr_q[31:26];
    assign funct = instr_q[5:0];

    always_comb begin
        MDUwrite = 4'd0;
        MDUcal   = 4'd0;
        MDUread  = 2'd0;
        RegWrite = 1'b0;
        RegDst   = 2'd0;
        ALUop    = 4'd0;
        ALUsrc   = 1'b0;
        ExtOp    = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        NPCsel   = 3'd0;
        known    = 1'b1;
        case (op)
            6'h00: begin
                case (funct)
                    6'h21: begin RegWrite = 1'b1; RegDst = 2'd1; ALUop = 4'd0; end
                    6'h23: begin RegWrite = 1'b1; RegDst = 2'd1; ALUop = 4'd1; end
                    6'h24: begin RegWrite = 1'b1; RegDst = 2'd1; ALUop = 4'd2; end
                    6'h25: begin RegWrite = 1'b1; RegDst = 2'd1; ALUop = 4'd3; end
                    6'h2A: begin RegWrite = 1'b1; RegDst = 2'd1; ALUop = 4'd4; end
                    6'h2B: begin RegWrite = 1'b1; RegDst = 2'd1; ALUop = 4'd5; end
                    6'h08: NPCsel = 3'd4;
`ifdef MDU_DECODE_EN
                    6'h10: begin MDUread = 2'd1; RegWrite = 1'b1; RegDst = 2'd1; end
                    6'h12: begin MDUread = 2'd2; RegWrite = 1'b1; RegDst = 2'd1; end
                    6'h11: MDUwrite = 4'd1;
                    6'h13: MDUwrite = 4'd2;
                    6'h18: MDUcal = 4'd1;
                    6'h19: MDUcal = 4'd2;
                    6'h1A: MDUcal = 4'd3;
                    6'h1B: MDUcal = 4'd4;
`endif
                    // Only the all-zero NOP is legal among the remaining funct codes
                    default: known = (instr_q == 32'h0);
                endcase
            end
            6'h0D: begin RegWrite = 1'b1; ALUop = 4'd3; ALUsrc = 1'b1; end
            6'h09: begin RegWrite = 1'b1; ALUop = 4'd0; ALUsrc = 1'b1; ExtOp = 1'b1; end
            6'h0F: begin RegWrite = 1'b1; ALUop = 4'd6; ALUsrc = 1'b1; end
            6'h23: begin RegWrite = 1'b1; ALUsrc = 1'b1; ExtOp = 1'b1; MemToReg = 1'b1; end
            6'h2B: begin MemWrite = 1'b1; ALUsrc = 1'b1; ExtOp = 1'b1; end
            6'h04: begin NPCsel = 3'd1; ALUop = 4'd1; ExtOp = 1'b1; end
            6'h05: begin NPCsel = 3'd2; ALUop = 4'd1; ExtOp = 1'b1; end
            6'h02: NPCsel = 3'd3;
            6'h03: begin NPCsel = 3'd3; RegWrite = 1'b1; RegDst = 2'd2; end
            default: known = 1'b0;
        endcase
        if (!known) begin
            MDUwrite = 4'd0;
            MDUcal   = 4'd0;
            MDUread  = 2'd0;
            RegWrite = 1'b0;
            RegDst   = 2'd0;
            ALUop    = 4'd0;
            ALUsrc   = 1'b0;
            ExtOp    = 1'b0;
            MemWrite = 1'b0;
            MemToReg = 1'b0;
            NPCsel   = 3'd0;
        end
    end

    assign start   = (MDUcal != 4'd0);
    assign illegal = ~known;

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - scoreboard bench for decoder with directed instruction vectors
module tb_decoder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Instr = 32'h01090018;
    logic        en = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  MDUwrite, MDUcal, ALUop;
    logic [1:0]  MDUread, RegDst;
    logic [2:0]  NPCsel;
    logic        start, RegWrite, ALUsrc, ExtOp, MemWrite, MemToReg, illegal;

    typedef struct packed {
        logic [3:0] mw;
        logic [3:0] mc;
        logic       st;
        logic [1:0] mr;
        logic       rw;
        logic [1:0] rd;
        logic [3:0] alu;
        logic       src;
        logic       ext;
        logic       mwr;
        logic       m2r;
        logic [2:0] npc;
        logic       ill;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    compared = 0;
    int    mismatched = 0;

    decoder dut (
        .clk(clk), .reset(reset), .Instr(Instr), .en(en), .flush(flush),
        .MDUwrite(MDUwrite), .MDUcal(MDUcal), .start(start), .MDUread(MDUread),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUop(ALUop), .ALUsrc(ALUsrc),
        .ExtOp(ExtOp), .MemWrite(MemWrite), .MemToReg(MemToReg), .NPCsel(NPCsel),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Argument order: MDUwrite MDUcal start MDUread RegWrite RegDst ALUop ALUsrc ExtOp MemWrite MemToReg NPCsel illegal
    function automatic exp_t mk(input int mw, mc, st, mr, rw, rd, alu, src, ext, mwr, m2r, npc, ill);
        exp_t e;
        e.mw = 4'(mw); e.mc = 4'(mc); e.st = 1'(st); e.mr = 2'(mr);
        e.rw = 1'(rw); e.rd = 2'(rd); e.alu = 4'(alu); e.src = 1'(src);
        e.ext = 1'(ext); e.mwr = 1'(mwr); e.m2r = 1'(m2r); e.npc = 3'(npc); e.ill = 1'(ill);
        return e;
    endfunction

    task automatic apply(input logic [31:0] ins, input logic e, input logic f, input exp_t x, input string nm);
        @(negedge clk);
        Instr = ins;
        en    = e;
        flush = f;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Monitor: output is valid one step after each clock edge or asynchronous reset assertion
    initial begin
        exp_t  act;
        exp_t  x;
        string nm;
        int    busy;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            while (exp_q.size() > 0) begin
                x  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {MDUwrite, MDUcal, start, MDUread, RegWrite, RegDst, ALUop,
                       ALUsrc, ExtOp, MemWrite, MemToReg, NPCsel, illegal};
                compared++;
                if (act !== x) begin
                    mismatched++;
                    $display("FAIL %s: got %h expected %h", nm, act, x);
                end
                busy = int'(start) + int'(MDUwrite != 4'd0) + int'(MDUread != 2'd0);
                compared++;
                if (busy > 1) begin
                    mismatched++;
                    $display("FAIL %s_mdu_exclusive: got %0d active expected at most 1", nm, busy);
                end
            end
        end
    end

    initial begin
        exp_t zero, ill, x_mult, x_divu, x_mthi, x_mtlo, x_mfhi;
        zero = mk(0,0,0,0,0,0,0,0,0,0,0,0,0);
        ill  = mk(0,0,0,0,0,0,0,0,0,0,0,0,1);
`ifdef MDU_DECODE_EN
        x_mult = mk(0,1,1,0,0,0,0,0,0,0,0,0,0);
        x_divu = mk(0,4,1,0,0,0,0,0,0,0,0,0,0);
        x_mthi = mk(1,0,0,0,0,0,0,0,0,0,0,0,0);
        x_mtlo = mk(2,0,0,0,0,0,0,0,0,0,0,0,0);
        x_mfhi = mk(0,0,0,1,1,1,0,0,0,0,0,0,0);
`else
        x_mult = ill;
        x_divu = ill;
        x_mthi = ill;
        x_mtlo = ill;
        x_mfhi = ill;
`endif
        apply(32'h01090018, 1'b1, 1'b0, zero, "reset_hold");
        @(negedge clk);
        reset = 1'b1;

        apply(32'h01090018, 1'b1, 1'b0, x_mult, "mult");
        apply(32'h0109001B, 1'b1, 1'b0, x_divu, "divu");
        apply(32'h01000011, 1'b1, 1'b0, x_mthi, "mthi");
        apply(32'h01000013, 1'b1, 1'b0, x_mtlo, "mtlo");
        apply(32'h00005010, 1'b1, 1'b0, x_mfhi, "mfhi");
        apply(32'h34080005, 1'b1, 1'b0, mk(0,0,0,0,1,0,3,1,0,0,0,0,0), "ori");
        apply(32'h01095021, 1'b1, 1'b0, mk(0,0,0,0,1,1,0,0,0,0,0,0,0), "addu");
        apply(32'h01095023, 1'b1, 1'b0, mk(0,0,0,0,1,1,1,0,0,0,0,0,0), "subu");
        apply(32'h01095024, 1'b1, 1'b0, mk(0,0,0,0,1,1,2,0,0,0,0,0,0), "and");
        apply(32'h01095025, 1'b1, 1'b0, mk(0,0,0,0,1,1,3,0,0,0,0,0,0), "or");
        apply(32'h0109502A, 1'b1, 1'b0, mk(0,0,0,0,1,1,4,0,0,0,0,0,0), "slt");
        apply(32'h0109502B, 1'b1, 1'b0, mk(0,0,0,0,1,1,5,0,0,0,0,0,0), "sltu");
        apply(32'h01000008, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0,4,0), "jr");
        apply(32'h25080001, 1'b1, 1'b0, mk(0,0,0,0,1,0,0,1,1,0,0,0,0), "addiu");
        apply(32'h3C081234, 1'b1, 1'b0, mk(0,0,0,0,1,0,6,1,0,0,0,0,0), "lui");
        apply(32'h8D280004, 1'b1, 1'b0, mk(0,0,0,0,1,0,0,1,1,0,1,0,0), "lw");
        apply(32'hAD280004, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,1,1,1,0,0,0), "sw");
        apply(32'h11090003, 1'b1, 1'b0, mk(0,0,0,0,0,0,1,0,1,0,0,1,0), "beq");
        apply(32'h15090003, 1'b1, 1'b0, mk(0,0,0,0,0,0,1,0,1,0,0,2,0), "bne");
        apply(32'h08000010, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0,3,0), "j");
        apply(32'h0C000010, 1'b1, 1'b0, mk(0,0,0,0,1,2,0,0,0,0,0,3,0), "jal");
        apply(32'h00000000, 1'b1, 1'b0, zero, "nop");
        apply(32'h00084080, 1'b1, 1'b0, ill, "sll_nonzero");
        apply(32'h0109502F, 1'b1, 1'b0, ill, "bad_funct");

        apply(32'h01090018, 1'b1, 1'b0, x_mult, "hold_load");
        apply(32'h34080005, 1'b0, 1'b0, x_mult, "hold_stall");
        apply(32'h34080005, 1'b1, 1'b1, zero, "flush_over_en");
        apply(32'h34080005, 1'b0, 1'b1, zero, "flush_no_en");

        apply(32'h01090018, 1'b1, 1'b0, x_mult, "pre_async");
        @(posedge clk);
        #2;
        exp_q.push_back(zero);
        name_q.push_back("async_reset");
        en = 1'b0;
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        apply(32'hFC000000, 1'b1, 1'b0, ill, "illegal_fc");

        repeat (3) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
